// File: rtl/hazard_scoreboard.sv
// Pipeline interlock and forwarding controller for the PMIPS core.
// Tracks in-flight destinations EX..WB in its own shift register and decides stall/flush/forward.
module hazard_scoreboard #(
    parameter int unsigned AW       = 3,
    parameter int unsigned DEPTH    = 3,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SW       = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic          id_rs_used,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rt_used,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_wr_addr,
    input  logic          id_is_load,
    input  logic          ex_br_taken,
    input  logic          ex_busy,
    output logic          stall,
    output logic          flush,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic [15:0]   stall_cnt
);

    localparam int D          = int'(DEPTH);
    localparam int ALU_READY  = FWD_EN ? 1 : D - 1;
    localparam int LOAD_READY = FWD_EN ? 1 + int'(LOAD_LAT) : D - 1;

    logic [DEPTH-1:0] valid_q, wr_en_q, load_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [SW-1:0]    fwd_a_q, fwd_b_q;
    logic [15:0]      stall_cnt_q;

    logic [DEPTH-1:0] match_a, match_b, early;
    logic             hazard;
    logic             advance;
    logic [SW-1:0]    fwd_a_d, fwd_b_d;

    always_comb begin
        match_a = '0;
        match_b = '0;
        early   = '0;
        hazard  = 1'b0;
        for (int k = 0; k < D; k++) begin
            match_a[k] = valid_q[k] && wr_en_q[k] && id_rs_used &&
                         (id_rs == addr_q[k]) && (id_rs != '0);
            match_b[k] = valid_q[k] && wr_en_q[k] && id_rt_used &&
                         (id_rt == addr_q[k]) && (id_rt != '0);
            early[k]   = (k + 1) < (load_q[k] ? LOAD_READY : ALU_READY);
            if ((match_a[k] || match_b[k]) && early[k]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        // A producer leaving WB is already visible through the register file, so only
        // slots 0..DEPTH-2 are forwarding sources; descending scan lets the youngest win.
        if (FWD_EN) begin
            for (int k = D - 2; k >= 0; k--) begin
                if (match_a[k] && !early[k]) fwd_a_d = SW'(k + 1);
                if (match_b[k] && !early[k]) fwd_b_d = SW'(k + 1);
            end
        end
    end

    assign flush   = ex_br_taken && !ex_busy;
    assign stall   = ex_busy || (hazard && !flush);
    assign advance = id_valid && !stall && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            wr_en_q     <= '0;
            load_q      <= '0;
            for (int k = 0; k < D; k++) begin
                addr_q[k] <= '0;
            end
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
        end else if (!ex_busy) begin
            for (int k = D - 1; k > 0; k--) begin
                valid_q[k] <= valid_q[k-1];
                wr_en_q[k] <= wr_en_q[k-1];
                load_q[k]  <= load_q[k-1];
                addr_q[k]  <= addr_q[k-1];
            end
            valid_q[0] <= advance;
            wr_en_q[0] <= advance && id_wr_en;
            load_q[0]  <= advance && id_is_load;
            addr_q[0]  <= id_wr_addr;
            fwd_a_q    <= advance ? fwd_a_d : '0;
            fwd_b_q    <= advance ? fwd_b_d : '0;
            if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one forwarding instance (DEPTH=3) and one
// register-file-only instance (DEPTH=4) driven from a shared vector table.
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
    logic [2:0] id_rs, id_rt, id_wr_addr;
    logic       ex_br_taken, ex_busy;

    logic        stall_a, flush_a, stall_b, flush_b;
    logic [1:0]  fwd_a_a, fwd_b_a, fwd_a_b, fwd_b_b;
    logic [15:0] cnt_a, cnt_b;

    always #5 clock = ~clock;

    hazard_scoreboard #(.AW(3), .DEPTH(3), .FWD_EN(1'b1), .LOAD_LAT(1)) u_fwd (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .ex_busy(ex_busy), .stall(stall_a), .flush(flush_a),
        .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.AW(3), .DEPTH(4), .FWD_EN(1'b0), .LOAD_LAT(1)) u_nofwd (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .ex_busy(ex_busy), .stall(stall_b), .flush(flush_b),
        .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall_cnt(cnt_b)
    );

    typedef struct {
        bit          rst;
        bit          sel;
        logic        valid;
        logic [2:0]  rs;
        logic        rs_used;
        logic [2:0]  rt;
        logic        rt_used;
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic        is_load;
        logic        br;
        logic        busy;
        logic        es;
        logic        ef;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        bit          sel;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(bit rst, bit sel, logic valid, logic [2:0] rs, logic rs_used,
                                logic [2:0] rt, logic rt_used, logic wr_en, logic [2:0] wr_addr,
                                logic is_load, logic br, logic busy, logic es, logic ef,
                                logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.sel = sel; v.valid = valid; v.rs = rs; v.rs_used = rs_used;
        v.rt = rt; v.rt_used = rt_used; v.wr_en = wr_en; v.wr_addr = wr_addr;
        v.is_load = is_load; v.br = br; v.busy = busy; v.es = es; v.ef = ef;
        v.fa = fa; v.fb = fb; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0;
        id_wr_en = 1'b0; id_wr_addr = 3'd0; id_is_load = 1'b0;
        ex_br_taken = 1'b0; ex_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs = v.rs; id_rs_used = v.rs_used; id_rt = v.rt;
        id_rt_used = v.rt_used; id_wr_en = v.wr_en; id_wr_addr = v.wr_addr;
        id_is_load = v.is_load; ex_br_taken = v.br; ex_busy = v.busy;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " A stall"}, {15'd0, stall_a}, 16'd0);
        check({tag, " A flush"}, {15'd0, flush_a}, 16'd0);
        check({tag, " A fwd_a"}, {14'd0, fwd_a_a}, 16'd0);
        check({tag, " A fwd_b"}, {14'd0, fwd_b_a}, 16'd0);
        check({tag, " A cnt"}, cnt_a, 16'd0);
        check({tag, " B stall"}, {15'd0, stall_b}, 16'd0);
        check({tag, " B fwd_a"}, {14'd0, fwd_a_b}, 16'd0);
        check({tag, " B cnt"}, cnt_b, 16'd0);
    endtask

    initial begin
        vec_t v;
        exp_t e;

        // ALU r3 then rs=r3 consumer: no stall, forward from slot 1
        vecs.push_back(mk(1, 0, 1, 3'd1, 1, 3'd2, 1, 1, 3'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd3, 1, 3'd5, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        // load r2 then rt=r2 consumer: one stall, forward from slot 2
        vecs.push_back(mk(1, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd1, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'd1));
        vecs.push_back(mk(0, 0, 1, 3'd1, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd1));
        vecs.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd1));
        // writer of r0, then reader of r0
        vecs.push_back(mk(1, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 1, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        // load-use with taken branch: flush wins, consumer (writes r5) becomes a bubble
        vecs.push_back(mk(1, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd2, 1, 3'd0, 0, 1, 3'd5, 0, 1, 0, 0, 1, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd5, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd0));
        // no forwarding, DEPTH=4: ALU r4 then reader stalls two cycles
        vecs.push_back(mk(1, 1, 1, 3'd1, 1, 3'd0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 1, 1, 3'd4, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'd1));
        vecs.push_back(mk(0, 1, 1, 3'd4, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'd2));
        vecs.push_back(mk(0, 1, 1, 3'd4, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd2));
        // freeze for 3 cycles over a pending load-use hazard (branch ignored while busy)
        vecs.push_back(mk(1, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd3, 1, 3'd0, 0, 1, 3'd2, 1, 0, 0, 0, 0, 2'd1, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 0, 1, 1, 0, 2'd1, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 1, 1, 1, 0, 2'd1, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 0, 1, 1, 0, 2'd1, 2'd0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'd1));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd1));
        vecs.push_back(mk(0, 0, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0, 0, 0, 1, 1, 0, 2'd0, 2'd2, 16'd1));

        idle_inputs();
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            drive(v);
            #2;
            check($sformatf("v%0d stall", i), {15'd0, v.sel ? stall_b : stall_a}, {15'd0, v.es});
            check($sformatf("v%0d flush", i), {15'd0, v.sel ? flush_b : flush_a}, {15'd0, v.ef});
            sb.push_back('{idx: i, sel: v.sel, fa: v.fa, fb: v.fb, cnt: v.cnt});
            @(posedge clock);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d fwd_a", e.idx), {14'd0, e.sel ? fwd_a_b : fwd_a_a},
                  {14'd0, e.fa});
            check($sformatf("v%0d fwd_b", e.idx), {14'd0, e.sel ? fwd_b_b : fwd_b_a},
                  {14'd0, e.fb});
            check($sformatf("v%0d stall_cnt", e.idx), e.sel ? cnt_b : cnt_a, e.cnt);
        end

        // still frozen with fwd_b=2 and stall_cnt=1: reset must clear without a clock edge
        check("pre-reset A fwd_b", {14'd0, fwd_b_a}, 16'd2);
        reset   = 1'b0;
        ex_busy = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
